// File: rtl/apb2pvci_pkg.sv
// Shared state encoding, default timeout and address check for the APB3-to-PVCI
// wait-state bridge.
package apb2pvci_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int unsigned TO_CYC_DEF = 16;

  // True for a misaligned word access, or for address bits above the PVCI window when checked.
  function automatic logic addr_err(input logic [31:0] paddr, input int unsigned addr_lsb,
                                    input int unsigned addr_w, input logic chk_upper);
    logic [31:0] lo_mask;
    logic        misalign;
    logic        upper;
    lo_mask  = (32'd1 << addr_lsb) - 32'd1;
    misalign = (paddr & lo_mask) != 32'd0;
    upper    = chk_upper && ((addr_lsb + addr_w) < 32'd32) &&
               ((paddr >> (addr_lsb + addr_w)) != 32'd0);
    return misalign || upper;
  endfunction

endpackage

// File: rtl/apb2pvci_ws_if.sv
// APB3 and PVCI bus bundles used by the bridge; the bridge is the APB slave and
// the PVCI master.
interface apb3_if;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        psel;
  logic        penable;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (output paddr, pwrite, pwdata, psel, penable,
                  input  prdata, pready, pslverr);
  modport slave  (input  paddr, pwrite, pwdata, psel, penable,
                  output prdata, pready, pslverr);
endinterface

interface pvci_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] pvci_addr;
  logic [DATA_W-1:0] pvci_wd;
  logic              pvci_rd;
  logic              pvci_valid;
  logic              pvci_ack;
  logic [DATA_W-1:0] pvci_rdata;

  modport master (output pvci_addr, pvci_wd, pvci_rd, pvci_valid,
                  input  pvci_ack, pvci_rdata);
  modport slave  (input  pvci_addr, pvci_wd, pvci_rd, pvci_valid,
                  output pvci_ack, pvci_rdata);
endinterface

// File: rtl/apb2pvci_ws_timeout_cnt.sv
// PVCI ack timeout counter: counts request cycles and flags the last allowed one.
module pvci_timeout_cnt #(
  parameter int unsigned TO_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire_c
);

  localparam int unsigned   CW    = (TO_CYC == 0) ? 1 : $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] LAST  = (TO_CYC == 0) ? '0 : CW'(TO_CYC - 1);
  localparam bit            TO_ON = (TO_CYC != 0);

  logic [CW-1:0] r_cnt;
  logic          w_en;

  // A zero timeout keeps the counter parked at zero and never expires.
  assign w_en       = i_en && TO_ON;
  assign o_expire_c = w_en && (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (w_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/apb2pvci_ws.sv
// APB3-to-PVCI bridge with PVCI wait states, ack timeout and pslverr reporting.
module apb2pvci_ws
  import apb2pvci_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_LSB  = 2,
  parameter int unsigned TO_CYC    = TO_CYC_DEF,
  parameter bit          CHK_UPPER = 1'b1
) (
  input  logic   pclk,
  input  logic   preset,
  apb3_if.slave  apb,
  pvci_if.master pvci
);

  logic [1:0]        r_state,   w_state;
  logic              r_err,     w_err;
  logic [31:0]       r_prdata,  w_prdata;
  logic              r_pready,  w_pready;
  logic              r_pslverr, w_pslverr;
  logic [ADDR_W-1:0] r_addr,    w_addr;
  logic [DATA_W-1:0] r_wd,      w_wd;
  logic              r_rd,      w_rd;
  logic              r_valid,   w_valid;
  logic              w_setup;
  logic              w_bad;
  logic              w_expire;

  assign w_setup = apb.psel && !apb.penable;
  assign w_bad   = addr_err(apb.paddr, ADDR_LSB, ADDR_W, CHK_UPPER);

  pvci_timeout_cnt #(.TO_CYC(TO_CYC)) u_to (
    .i_clk      (pclk),
    .i_rst      (preset),
    .i_clr      (r_state != S_REQ),
    .i_en       (r_state == S_REQ),
    .o_expire_c (w_expire)
  );

  // Next-state and next-output decode; pready/pslverr are decodes of the next state.
  always_comb begin
    w_state   = r_state;
    w_err     = r_err;
    w_prdata  = r_prdata;
    w_addr    = r_addr;
    w_wd      = r_wd;
    w_rd      = r_rd;
    w_valid   = r_valid;
    w_pready  = 1'b0;
    w_pslverr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          w_addr = apb.paddr[ADDR_LSB +: ADDR_W];
          w_wd   = apb.pwdata[DATA_W-1:0];
          w_rd   = !apb.pwrite;
          if (w_bad) begin
            w_err   = 1'b1;
            w_state = S_RESP;
          end else begin
            w_valid = 1'b1;
            w_state = S_REQ;
          end
        end
      end
      S_REQ: begin
        // An ack in the expiring cycle still completes the access cleanly.
        if (pvci.pvci_ack) begin
          w_valid = 1'b0;
          if (r_rd) begin
            w_prdata = 32'(pvci.pvci_rdata);
          end
          w_state = S_RESP;
        end else if (w_expire) begin
          w_valid  = 1'b0;
          w_err    = 1'b1;
          w_prdata = 32'd0;
          w_state  = S_RESP;
        end
      end
      S_RESP: begin
        w_err   = 1'b0;
        w_state = S_IDLE;
      end
      default: begin
        w_valid = 1'b0;
        w_err   = 1'b0;
        w_state = S_IDLE;
      end
    endcase
    w_pready  = (w_state == S_RESP);
    w_pslverr = (w_state == S_RESP) && w_err;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state   <= S_IDLE;
      r_err     <= 1'b0;
      r_prdata  <= 32'd0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_addr    <= '0;
      r_wd      <= '0;
      r_rd      <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_err     <= w_err;
      r_prdata  <= w_prdata;
      r_pready  <= w_pready;
      r_pslverr <= w_pslverr;
      r_addr    <= w_addr;
      r_wd      <= w_wd;
      r_rd      <= w_rd;
      r_valid   <= w_valid;
    end
  end

  assign apb.prdata      = r_prdata;
  assign apb.pready      = r_pready;
  assign apb.pslverr     = r_pslverr;
  assign pvci.pvci_addr  = r_addr;
  assign pvci.pvci_wd    = r_wd;
  assign pvci.pvci_rd    = r_rd;
  assign pvci.pvci_valid = r_valid;

endmodule

// File: tb/tb_apb2pvci_ws.sv
// Bench for apb2pvci_ws: three parameterisations share one APB/PVCI driver,
// selected by sel; expectations come from a small model through a scoreboard.
module tb_apb2pvci_ws;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        preset;
  logic [31:0] paddr, pwdata, rdata;
  logic        pwrite, psel, penable, ack;
  int          sel;

  always #5 clk = ~clk;

  apb3_if a0 ();
  apb3_if a1 ();
  apb3_if a2 ();
  pvci_if #(.ADDR_W(8), .DATA_W(8))  v0 ();
  pvci_if #(.ADDR_W(8), .DATA_W(8))  v1 ();
  pvci_if #(.ADDR_W(6), .DATA_W(32)) v2 ();

  assign a0.paddr = paddr;  assign a1.paddr = paddr;  assign a2.paddr = paddr;
  assign a0.pwrite = pwrite; assign a1.pwrite = pwrite; assign a2.pwrite = pwrite;
  assign a0.pwdata = pwdata; assign a1.pwdata = pwdata; assign a2.pwdata = pwdata;
  assign a0.penable = penable; assign a1.penable = penable; assign a2.penable = penable;
  assign a0.psel = psel && (sel == 0);
  assign a1.psel = psel && (sel == 1);
  assign a2.psel = psel && (sel == 2);
  assign v0.pvci_ack = ack && (sel == 0);
  assign v1.pvci_ack = ack && (sel == 1);
  assign v2.pvci_ack = ack && (sel == 2);
  assign v0.pvci_rdata = rdata[7:0];
  assign v1.pvci_rdata = rdata[7:0];
  assign v2.pvci_rdata = rdata;

  apb2pvci_ws #(.ADDR_W(8), .DATA_W(8), .ADDR_LSB(2), .TO_CYC(TO), .CHK_UPPER(1'b1)) u0 (
    .pclk(clk), .preset(preset), .apb(a0), .pvci(v0));
  apb2pvci_ws #(.ADDR_W(8), .DATA_W(8), .ADDR_LSB(2), .TO_CYC(TO), .CHK_UPPER(1'b0)) u1 (
    .pclk(clk), .preset(preset), .apb(a1), .pvci(v1));
  apb2pvci_ws #(.ADDR_W(6), .DATA_W(32), .ADDR_LSB(2), .TO_CYC(TO), .CHK_UPPER(1'b1)) u2 (
    .pclk(clk), .preset(preset), .apb(a2), .pvci(v2));

  logic [31:0] m_prdata, m_addr, m_wd;
  logic        m_pready, m_pslverr, m_valid, m_rd;

  always_comb begin
    m_prdata = a0.prdata; m_pready = a0.pready; m_pslverr = a0.pslverr;
    m_addr = 32'(v0.pvci_addr); m_wd = 32'(v0.pvci_wd); m_rd = v0.pvci_rd; m_valid = v0.pvci_valid;
    if (sel == 1) begin
      m_prdata = a1.prdata; m_pready = a1.pready; m_pslverr = a1.pslverr;
      m_addr = 32'(v1.pvci_addr); m_wd = 32'(v1.pvci_wd); m_rd = v1.pvci_rd; m_valid = v1.pvci_valid;
    end else if (sel == 2) begin
      m_prdata = a2.prdata; m_pready = a2.pready; m_pslverr = a2.pslverr;
      m_addr = 32'(v2.pvci_addr); m_wd = 32'(v2.pvci_wd); m_rd = v2.pvci_rd; m_valid = v2.pvci_valid;
    end
  end

  typedef struct {
    logic [31:0] prdata;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rd;
    int          vcnt;
    int          lat;
  } exp_t;

  typedef struct {
    logic        got;
    logic [31:0] prdata;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rd;
    int          vcnt;
    int          lat;
  } obs_t;

  exp_t        sb[$];
  logic [31:0] model_prd [3];
  int          n_vec = 0;
  int          n_err = 0;

  // Reference behaviour of one transfer on the currently selected instance.
  function automatic exp_t model(input logic [31:0] a, input logic w, input logic [31:0] d,
                                 input int ack_at, input logic [31:0] rd_in);
    int unsigned aw = (sel == 2) ? 6 : 8;
    logic [31:0] dm = (sel == 2) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    logic        chk = (sel != 1);
    exp_t        e;
    e.addr = (a >> 2) & ((32'd1 << aw) - 32'd1);
    e.wd   = d & dm;
    e.rd   = !w;
    e.err  = (a[1:0] != 2'b00) || (chk && ((a >> (2 + aw)) != 32'd0));
    if (e.err) begin
      e.vcnt = 0; e.lat = 1; e.prdata = model_prd[sel];
    end else if (ack_at < 1 || ack_at > int'(TO)) begin
      e.vcnt = int'(TO); e.lat = int'(TO) + 1; e.err = 1'b1; e.prdata = 32'd0;
    end else begin
      e.vcnt = ack_at; e.lat = ack_at + 1;
      e.prdata = w ? model_prd[sel] : (rd_in & dm);
    end
    model_prd[sel] = e.prdata;
    return e;
  endfunction

  // One APB transfer; returns at the negedge of the pready cycle with psel still high.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input int ack_at, input logic [31:0] rd_in, output obs_t o);
    o = '{got: 1'b0, prdata: 32'd0, err: 1'b0, addr: 32'd0, wd: 32'd0, rd: 1'b0, vcnt: 0, lat: 0};
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d; ack = 1'b0; rdata = rd_in;
    @(negedge clk);
    penable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      ack = 1'b0;
      if (m_valid) begin
        o.vcnt++;
        o.addr = m_addr; o.wd = m_wd; o.rd = m_rd;
        if (o.vcnt == ack_at) ack = 1'b1;
      end
      if (m_pready) begin
        o.got = 1'b1; o.lat = c; o.prdata = m_prdata; o.err = m_pslverr;
        break;
      end
      @(negedge clk);
    end
    ack = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    preset = 1'b1;
    repeat (3) @(negedge clk);
    preset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_vec++; if (m_prdata !== 32'd0) begin n_err++; $display("FAIL reset[%0d] prdata got %h want 0", s, m_prdata); end
      n_vec++; if ({m_pready, m_pslverr, m_valid, m_rd} !== 4'b0000) begin n_err++; $display("FAIL reset[%0d] pready/pslverr/valid/rd got %b want 0000", s, {m_pready, m_pslverr, m_valid, m_rd}); end
      n_vec++; if (m_addr !== 32'd0) begin n_err++; $display("FAIL reset[%0d] pvci_addr got %h want 0", s, m_addr); end
      n_vec++; if (m_wd !== 32'd0) begin n_err++; $display("FAIL reset[%0d] pvci_wd got %h want 0", s, m_wd); end
    end
    for (int s = 0; s < 3; s++) model_prd[s] = 32'd0;
  endtask

  task automatic test_basic();
    logic [31:0] t_a [2] = '{32'h0000_0014, 32'h0000_0008};
    logic        t_w [2] = '{1'b1, 1'b0};
    logic [31:0] t_d [2] = '{32'h0000_005A, 32'h0000_0000};
    int          t_k [2] = '{1, 3};
    logic [31:0] t_r [2] = '{32'h0000_0000, 32'h0000_00C3};
    exp_t e; obs_t o;
    sel = 0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model(t_a[i], t_w[i], t_d[i], t_k[i], t_r[i]));
      xfer(t_a[i], t_w[i], t_d[i], t_k[i], t_r[i], o);
      idle();
      e = sb.pop_front();
      n_vec++; if (o.got !== 1'b1) begin n_err++; $display("FAIL basic[%0d] pready seen %0b want 1", i, o.got); end
      n_vec++; if (o.lat !== e.lat) begin n_err++; $display("FAIL basic[%0d] pready latency %0d want %0d", i, o.lat, e.lat); end
      n_vec++; if (o.vcnt !== e.vcnt) begin n_err++; $display("FAIL basic[%0d] pvci_valid cycles %0d want %0d", i, o.vcnt, e.vcnt); end
      n_vec++; if (o.err !== e.err) begin n_err++; $display("FAIL basic[%0d] pslverr got %0b want %0b", i, o.err, e.err); end
      n_vec++; if (o.prdata !== e.prdata) begin n_err++; $display("FAIL basic[%0d] prdata got %h want %h", i, o.prdata, e.prdata); end
      if (e.vcnt > 0) begin
        n_vec++; if ({o.addr, o.wd, o.rd} !== {e.addr, e.wd, e.rd}) begin n_err++; $display("FAIL basic[%0d] pvci addr/wd/rd got %h/%h/%0b want %h/%h/%0b", i, o.addr, o.wd, o.rd, e.addr, e.wd, e.rd); end
      end
    end
  endtask

  task automatic test_errors();
    int          t_s [4] = '{0, 0, 1, 2};
    logic [31:0] t_a [4] = '{32'h0000_0009, 32'h0000_0400, 32'h0000_0400, 32'h0000_0100};
    logic        t_w [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_d [4] = '{32'h0000_0011, 32'h0, 32'h0000_00A5, 32'h0};
    exp_t e; obs_t o;
    for (int i = 0; i < 4; i++) begin
      sel = t_s[i];
      sb.push_back(model(t_a[i], t_w[i], t_d[i], 1, 32'h0000_0055));
      xfer(t_a[i], t_w[i], t_d[i], 1, 32'h0000_0055, o);
      idle();
      e = sb.pop_front();
      n_vec++; if (o.got !== 1'b1) begin n_err++; $display("FAIL err[%0d] pready seen %0b want 1", i, o.got); end
      n_vec++; if (o.lat !== e.lat) begin n_err++; $display("FAIL err[%0d] pready latency %0d want %0d", i, o.lat, e.lat); end
      n_vec++; if (o.vcnt !== e.vcnt) begin n_err++; $display("FAIL err[%0d] pvci_valid cycles %0d want %0d", i, o.vcnt, e.vcnt); end
      n_vec++; if (o.err !== e.err) begin n_err++; $display("FAIL err[%0d] pslverr got %0b want %0b", i, o.err, e.err); end
      n_vec++; if (o.prdata !== e.prdata) begin n_err++; $display("FAIL err[%0d] prdata got %h want %h", i, o.prdata, e.prdata); end
      if (e.vcnt > 0) begin
        n_vec++; if ({o.addr, o.wd, o.rd} !== {e.addr, e.wd, e.rd}) begin n_err++; $display("FAIL err[%0d] pvci addr/wd/rd got %h/%h/%0b want %h/%h/%0b", i, o.addr, o.wd, o.rd, e.addr, e.wd, e.rd); end
      end
    end
  endtask

  task automatic test_timeout();
    int          t_k [2] = '{0, 16};
    logic [31:0] t_r [2] = '{32'h0000_00AA, 32'h0000_003C};
    exp_t e; obs_t o;
    sel = 0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model(32'h0000_0008, 1'b0, 32'h0, t_k[i], t_r[i]));
      xfer(32'h0000_0008, 1'b0, 32'h0, t_k[i], t_r[i], o);
      idle();
      e = sb.pop_front();
      n_vec++; if (o.got !== 1'b1) begin n_err++; $display("FAIL tmo[%0d] pready seen %0b want 1", i, o.got); end
      n_vec++; if (o.lat !== e.lat) begin n_err++; $display("FAIL tmo[%0d] pready latency %0d want %0d", i, o.lat, e.lat); end
      n_vec++; if (o.vcnt !== e.vcnt) begin n_err++; $display("FAIL tmo[%0d] pvci_valid cycles %0d want %0d", i, o.vcnt, e.vcnt); end
      n_vec++; if (o.err !== e.err) begin n_err++; $display("FAIL tmo[%0d] pslverr got %0b want %0b", i, o.err, e.err); end
      n_vec++; if (o.prdata !== e.prdata) begin n_err++; $display("FAIL tmo[%0d] prdata got %h want %h", i, o.prdata, e.prdata); end
    end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0018; pwrite = 1'b1; pwdata = 32'h0000_0066; ack = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    n_vec++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL rstmid pvci_valid in REQ got %0b want 1", m_valid); end
    @(negedge clk);
    preset = 1'b1;
    @(negedge clk);
    n_vec++; if ({m_valid, m_pready, m_pslverr, m_rd} !== 4'b0000) begin n_err++; $display("FAIL rstmid valid/pready/pslverr/rd got %b want 0000", {m_valid, m_pready, m_pslverr, m_rd}); end
    n_vec++; if ({m_prdata, m_addr, m_wd} !== 96'd0) begin n_err++; $display("FAIL rstmid prdata/addr/wd got %h/%h/%h want 0", m_prdata, m_addr, m_wd); end
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    for (int s = 0; s < 3; s++) model_prd[s] = 32'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++; if ({m_pready, m_valid} !== 2'b00) begin n_err++; $display("FAIL rstmid after[%0d] pready/valid got %b want 00", c, {m_pready, m_valid}); end
    end
  endtask

  task automatic test_back_to_back();
    int          t_s [8] = '{0, 0, 0, 0, 2, 2, 2, 2};
    logic [31:0] t_a [8] = '{32'h10, 32'h04, 32'h0C, 32'h20, 32'h10, 32'h04, 32'h0C, 32'hFC};
    logic        t_w [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_d [8] = '{32'h11, 32'h0, 32'h22, 32'h0, 32'h1234_5678, 32'h0, 32'hCAFE_F00D, 32'h0};
    int          t_k [8] = '{1, 2, 1, 1, 1, 2, 1, 3};
    logic [31:0] t_r [8] = '{32'h0, 32'h77, 32'h0, 32'h99, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0BAD_F00D};
    exp_t e; obs_t o;
    for (int i = 0; i < 8; i++) begin
      sel = t_s[i];
      sb.push_back(model(t_a[i], t_w[i], t_d[i], t_k[i], t_r[i]));
      xfer(t_a[i], t_w[i], t_d[i], t_k[i], t_r[i], o);
      if (i == 3 || i == 7) idle();
      e = sb.pop_front();
      n_vec++; if (o.got !== 1'b1) begin n_err++; $display("FAIL b2b[%0d] pready seen %0b want 1", i, o.got); end
      n_vec++; if (o.lat !== e.lat) begin n_err++; $display("FAIL b2b[%0d] pready latency %0d want %0d", i, o.lat, e.lat); end
      n_vec++; if (o.vcnt !== e.vcnt) begin n_err++; $display("FAIL b2b[%0d] pvci_valid cycles %0d want %0d", i, o.vcnt, e.vcnt); end
      n_vec++; if (o.err !== e.err) begin n_err++; $display("FAIL b2b[%0d] pslverr got %0b want %0b", i, o.err, e.err); end
      n_vec++; if (o.prdata !== e.prdata) begin n_err++; $display("FAIL b2b[%0d] prdata got %h want %h", i, o.prdata, e.prdata); end
      n_vec++; if ({o.addr, o.wd, o.rd} !== {e.addr, e.wd, e.rd}) begin n_err++; $display("FAIL b2b[%0d] pvci addr/wd/rd got %h/%h/%0b want %h/%h/%0b", i, o.addr, o.wd, o.rd, e.addr, e.wd, e.rd); end
    end
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0; rdata = 32'd0; ack = 1'b0; sel = 0;
    for (int s = 0; s < 3; s++) model_prd[s] = 32'd0;
    test_reset();
    test_basic();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard left %0d entries want 0", sb.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1);
  end

endmodule
